// File: rtl/rd_req_sched.sv
// rd_req_sched
// Read-request scheduler between the L1 caches / instruction prefetcher and
// the cache-to-AXI bridge.
//  - Arbitrates the bridge's single instruction read port between icache
//    refills and prefetcher line fetches. The icache normally wins. After
//    STARVE_LIMIT denied prefetch cycles the prefetcher wins one grant.
//  - Remembers who owns each outstanding instruction read in a small FIFO.
//    Bridge returns are routed back to that owner with zero latency.
//  - Tracks up to two dcache writes that are still waiting for br_wr_ok.
//    A dcache read to the same 16-byte line is held until that write is
//    acknowledged, so a read never overtakes a pending write.
//  - Flags returns and write acknowledges that have no tracked owner
//    (err_orphan, sticky until reset).
//
// Ports
//  clk, reset                      clock, asynchronous active-high reset
//  ic_req/ic_type/ic_addr, ic_rdy  icache refill request and accept
//  pf_req/pf_addr, pf_rdy          prefetch request (type 2'b10) and accept
//  ret_data, ic_ret_valid,
//  pf_ret_valid                    routed instruction return
//  dc_rd_req/dc_rd_addr, dc_rd_rdy dcache read request and accept
//  dc_wr_req/dc_wr_addr, dc_wr_rdy dcache write request and accept
//  br_inst_rd_*                    bridge instruction read channel
//  br_inst_ret_valid/_data         bridge instruction return
//  br_data_rd_req/_rdy             bridge data read handshake
//  br_wr_req/_rdy, br_wr_ok        bridge write handshake and write response
//  err_orphan                      sticky orphan return / write-ok flag
module rd_req_sched #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ic_req,
  input  logic [1:0]   ic_type,
  input  logic [31:0]  ic_addr,
  output logic         ic_rdy,
  input  logic         pf_req,
  input  logic [31:0]  pf_addr,
  output logic         pf_rdy,
  output logic [511:0] ret_data,
  output logic         ic_ret_valid,
  output logic         pf_ret_valid,
  input  logic         dc_rd_req,
  input  logic [31:0]  dc_rd_addr,
  output logic         dc_rd_rdy,
  input  logic         dc_wr_req,
  input  logic [31:0]  dc_wr_addr,
  output logic         dc_wr_rdy,
  output logic         br_inst_rd_req,
  output logic [1:0]   br_inst_rd_type,
  output logic [31:0]  br_inst_rd_addr,
  input  logic         br_inst_rd_rdy,
  input  logic         br_inst_ret_valid,
  input  logic [511:0] br_inst_ret_data,
  output logic         br_data_rd_req,
  input  logic         br_data_rd_rdy,
  output logic         br_wr_req,
  input  logic         br_wr_rdy,
  input  logic         br_wr_ok,
  output logic         err_orphan
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  // Owner FIFO: one bit per outstanding instruction read, 1 = prefetcher.
  logic [MAX_OUTSTANDING-1:0] own_q;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              own_cnt;

  logic [7:0] starve_cnt;

  // Write table, kept compacted: entry 0 is always the oldest, and
  // entry 1 can only be valid when entry 0 is valid.
  logic [1:0]  wt_valid;
  logic [27:0] wt_line [2];
  logic [1:0]  wt_valid_nxt;
  logic [27:0] wt_line_nxt [2];

  logic full;
  logic starved;
  logic ic_open;
  logic pf_open;
  logic sel_pf;
  logic ifire;
  logic pf_fire;
  logic ret_pop;
  logic head_pf;
  logic wt_room;
  logic dw_fire;
  logic wt_pop;
  logic hazard;

  // Arbitration. The "open" terms are the grants ignoring bridge readiness;
  // the request to the bridge must not depend on its own ready. When both
  // sources request, ic_open and pf_open are mutually exclusive.
  assign full    = (own_cnt == CW'(MAX_OUTSTANDING));
  assign starved = (starve_cnt == 8'(STARVE_LIMIT));
  assign ic_open = ~full & ~(starved & pf_req);
  assign pf_open = ~full & (starved | ~ic_req);
  assign sel_pf  = pf_req & pf_open;

  assign ic_rdy          = br_inst_rd_rdy & ic_open;
  assign pf_rdy          = br_inst_rd_rdy & pf_open;
  assign br_inst_rd_req  = (ic_req & ic_open) | sel_pf;
  assign br_inst_rd_addr = sel_pf ? pf_addr : ic_addr;
  assign br_inst_rd_type = sel_pf ? 2'b10 : ic_type;

  assign ifire   = br_inst_rd_req & br_inst_rd_rdy;
  assign pf_fire = pf_req & pf_rdy;

  // Return routing: a return is matched to the FIFO head in the same cycle.
  // Returns arriving while nothing is outstanding are dropped.
  assign ret_pop      = br_inst_ret_valid & (own_cnt != '0);
  assign head_pf      = own_q[rd_ptr];
  assign ic_ret_valid = ret_pop & ~head_pf;
  assign pf_ret_valid = ret_pop & head_pf;
  assign ret_data     = br_inst_ret_data;

  // Write throttling and read-after-write hazard detection. A write that
  // fires in this same cycle also counts as pending for the read.
  assign wt_room   = ~wt_valid[1];
  assign dc_wr_rdy = br_wr_rdy & wt_room;
  assign br_wr_req = dc_wr_req & wt_room;
  assign dw_fire   = dc_wr_req & dc_wr_rdy;
  assign wt_pop    = br_wr_ok & wt_valid[0];

  assign hazard = (wt_valid[0] & (wt_line[0] == dc_rd_addr[31:4])) |
                  (wt_valid[1] & (wt_line[1] == dc_rd_addr[31:4])) |
                  (dw_fire & (dc_wr_addr[31:4] == dc_rd_addr[31:4]));

  assign dc_rd_rdy      = br_data_rd_rdy & ~hazard;
  assign br_data_rd_req = dc_rd_req & ~hazard;

  // Owner FIFO and occupancy. A push is impossible when full, so a
  // simultaneous push and pop never overruns the storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      own_cnt <= '0;
    end else begin
      if (ifire) begin
        own_q[wr_ptr] <= sel_pf;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (ret_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (ifire && !ret_pop) begin
        own_cnt <= own_cnt + 1'b1;
      end else if (!ifire && ret_pop) begin
        own_cnt <= own_cnt - 1'b1;
      end
    end
  end

  // Starvation counter counts consecutive cycles the prefetcher asked and
  // was refused, saturating at the limit so the grant stays armed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!pf_req || pf_fire) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Write table update: retire the oldest first, then append the new write
  // into the first free slot of the compacted table.
  always_comb begin
    wt_valid_nxt   = wt_valid;
    wt_line_nxt[0] = wt_line[0];
    wt_line_nxt[1] = wt_line[1];
    if (wt_pop) begin
      wt_valid_nxt   = {1'b0, wt_valid[1]};
      wt_line_nxt[0] = wt_line[1];
    end
    if (dw_fire) begin
      if (!wt_valid_nxt[0]) begin
        wt_valid_nxt[0] = 1'b1;
        wt_line_nxt[0]  = dc_wr_addr[31:4];
      end else begin
        wt_valid_nxt[1] = 1'b1;
        wt_line_nxt[1]  = dc_wr_addr[31:4];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wt_valid   <= '0;
      wt_line[0] <= '0;
      wt_line[1] <= '0;
    end else begin
      wt_valid   <= wt_valid_nxt;
      wt_line[0] <= wt_line_nxt[0];
      wt_line[1] <= wt_line_nxt[1];
    end
  end

  // Sticky orphan flag: an instruction return or write acknowledge that
  // nothing was waiting for, typically bridge traffic surviving a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_orphan <= 1'b0;
    end else if ((br_inst_ret_valid && own_cnt == '0) || (br_wr_ok && !wt_valid[0])) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rd_req_sched.sv
// tb_rd_req_sched
// Self-checking bench for rd_req_sched. Inputs are driven on the falling
// edge and outputs compared one time unit later against a reference model
// that keeps outstanding instruction owners and pending write lines in
// queues. Model state advances once per cycle with the same inputs the DUT
// sees on the following rising edge.
module tb_rd_req_sched;

  localparam int MAX_OUT = 4;
  localparam int LIMIT   = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ic_req, pf_req, dc_rd_req, dc_wr_req;
  logic [1:0]   ic_type;
  logic [31:0]  ic_addr, pf_addr, dc_rd_addr, dc_wr_addr;
  logic         ic_rdy, pf_rdy, dc_rd_rdy, dc_wr_rdy;
  logic [511:0] ret_data, br_inst_ret_data;
  logic         ic_ret_valid, pf_ret_valid;
  logic         br_inst_rd_req, br_inst_rd_rdy, br_inst_ret_valid;
  logic [1:0]   br_inst_rd_type;
  logic [31:0]  br_inst_rd_addr;
  logic         br_data_rd_req, br_data_rd_rdy;
  logic         br_wr_req, br_wr_rdy, br_wr_ok;
  logic         err_orphan;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  // Reference model state
  bit          owner_q[$];
  logic [27:0] write_q[$];
  int          starve = 0;
  bit          err_model = 1'b0;

  rd_req_sched #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_type(ic_type), .ic_addr(ic_addr), .ic_rdy(ic_rdy),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_rdy(pf_rdy),
    .ret_data(ret_data), .ic_ret_valid(ic_ret_valid), .pf_ret_valid(pf_ret_valid),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_rdy(dc_wr_rdy),
    .br_inst_rd_req(br_inst_rd_req), .br_inst_rd_type(br_inst_rd_type),
    .br_inst_rd_addr(br_inst_rd_addr), .br_inst_rd_rdy(br_inst_rd_rdy),
    .br_inst_ret_valid(br_inst_ret_valid), .br_inst_ret_data(br_inst_ret_data),
    .br_data_rd_req(br_data_rd_req), .br_data_rd_rdy(br_data_rd_rdy),
    .br_wr_req(br_wr_req), .br_wr_rdy(br_wr_rdy), .br_wr_ok(br_wr_ok),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  // Addresses confined to four neighbouring lines so reads and writes collide often.
  function automatic logic [31:0] mk_addr();
    logic [31:0] a;
    a = 32'h1000_0040 + 32'($urandom_range(0, 3) * 16) + 32'($urandom_range(0, 15));
    return a;
  endfunction

  // Modes: 0 reset, 1 starvation pattern, 2 random, 3 orphan return, 4 idle
  task automatic applyStimulus(input int mode, input int k);
    reset = 1'b0;
    ic_req = 1'b0; pf_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
    ic_type = 2'($urandom_range(0, 3));
    ic_addr = $urandom; pf_addr = $urandom;
    dc_rd_addr = mk_addr(); dc_wr_addr = mk_addr();
    br_inst_rd_rdy = 1'b0; br_inst_ret_valid = 1'b0;
    for (int w = 0; w < 16; w++) br_inst_ret_data[w*32 +: 32] = $urandom;
    br_data_rd_rdy = 1'b0; br_wr_rdy = 1'b0; br_wr_ok = 1'b0;
    case (mode)
      0: reset = 1'b1;
      1: begin
        ic_req = 1'b1; pf_req = 1'b1; br_inst_rd_rdy = 1'b1;
        br_inst_ret_valid = (owner_q.size() > 0);
      end
      2: begin
        reset = ((k % 200) == 199);
        ic_req = ($urandom_range(0, 3) != 0);
        pf_req = ($urandom_range(0, 7) != 0);
        br_inst_rd_rdy = ($urandom_range(0, 3) != 0);
        br_inst_ret_valid = (owner_q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                                 : ($urandom_range(0, 49) == 0);
        dc_rd_req = ($urandom_range(0, 1) == 1);
        dc_wr_req = ($urandom_range(0, 1) == 1);
        br_data_rd_rdy = ($urandom_range(0, 4) != 0);
        br_wr_rdy = ($urandom_range(0, 4) != 0);
        br_wr_ok = (write_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                        : ($urandom_range(0, 49) == 0);
      end
      3: br_inst_ret_valid = 1'b1;
      default: ;
    endcase
  endtask

  // Expected outputs from the model, then advance the model by one cycle.
  task automatic evaluate();
    bit full, starved, ic_open, pf_open, sel_pf, e_req, e_pf_rdy;
    bit pop_ok, head_pf, w_room, dwf, haz;
    if (reset) begin
      owner_q.delete(); write_q.delete(); starve = 0; err_model = 1'b0;
    end
    full    = (owner_q.size() >= MAX_OUT);
    starved = (starve == LIMIT);
    ic_open = !full && !(starved && pf_req);
    pf_open = !full && (starved || !ic_req);
    sel_pf  = pf_req && pf_open;
    e_req   = (ic_req && ic_open) || sel_pf;
    e_pf_rdy = br_inst_rd_rdy && pf_open;
    pop_ok  = br_inst_ret_valid && (owner_q.size() > 0);
    head_pf = (owner_q.size() > 0) ? owner_q[0] : 1'b0;
    w_room  = (write_q.size() < 2);
    dwf     = dc_wr_req && br_wr_rdy && w_room;
    haz     = dwf && (dc_wr_addr[31:4] == dc_rd_addr[31:4]);
    foreach (write_q[i]) if (write_q[i] == dc_rd_addr[31:4]) haz = 1'b1;

    checkOutput("ic_rdy", 64'(ic_rdy), 64'(br_inst_rd_rdy && ic_open));
    checkOutput("pf_rdy", 64'(pf_rdy), 64'(e_pf_rdy));
    checkOutput("br_inst_rd_req", 64'(br_inst_rd_req), 64'(e_req));
    if (e_req) begin
      checkOutput("br_inst_rd_addr", 64'(br_inst_rd_addr), 64'(sel_pf ? pf_addr : ic_addr));
      checkOutput("br_inst_rd_type", 64'(br_inst_rd_type), 64'(sel_pf ? 2'b10 : ic_type));
    end
    checkOutput("ic_ret_valid", 64'(ic_ret_valid), 64'(pop_ok && !head_pf));
    checkOutput("pf_ret_valid", 64'(pf_ret_valid), 64'(pop_ok && head_pf));
    checkOutput("ret_data_lo", ret_data[63:0], br_inst_ret_data[63:0]);
    checkOutput("ret_data_hi", ret_data[511:448], br_inst_ret_data[511:448]);
    checkOutput("dc_wr_rdy", 64'(dc_wr_rdy), 64'(br_wr_rdy && w_room));
    checkOutput("br_wr_req", 64'(br_wr_req), 64'(dc_wr_req && w_room));
    checkOutput("dc_rd_rdy", 64'(dc_rd_rdy), 64'(br_data_rd_rdy && !haz));
    checkOutput("br_data_rd_req", 64'(br_data_rd_req), 64'(dc_rd_req && !haz));
    checkOutput("err_orphan", 64'(err_orphan), 64'(err_model));

    if (!reset) begin
      if (br_inst_ret_valid) begin
        if (owner_q.size() > 0) void'(owner_q.pop_front());
        else err_model = 1'b1;
      end
      if (e_req && br_inst_rd_rdy) owner_q.push_back(sel_pf);
      if (pf_req && !e_pf_rdy) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else starve = 0;
      if (br_wr_ok) begin
        if (write_q.size() > 0) void'(write_q.pop_front());
        else err_model = 1'b1;
      end
      if (dwf) write_q.push_back(dc_wr_addr[31:4]);
    end
  endtask

  task automatic step(input int mode, input int k);
    @(negedge clk);
    cycle++;
    applyStimulus(mode, k);
    #1;
    evaluate();
  endtask

  initial begin
    $display("[TB] rd_req_sched bench start");
    step(0, 0);
    step(0, 0);

    // Both sources held: LIMIT icache grants, then one prefetch grant.
    for (int k = 0; k < LIMIT + 4; k++) begin
      step(1, k);
      checkOutput("starve_pf_grant", 64'(pf_rdy), 64'(k == LIMIT));
      checkOutput("starve_ic_grant", 64'(ic_rdy), 64'(k != LIMIT));
    end

    // Return with nothing outstanding: dropped, flag sticks until reset.
    step(0, 0);
    step(3, 0);
    checkOutput("orphan_no_ic_pulse", 64'(ic_ret_valid), 64'd0);
    checkOutput("orphan_no_pf_pulse", 64'(pf_ret_valid), 64'd0);
    step(4, 0);
    checkOutput("orphan_sticky", 64'(err_orphan), 64'd1);
    step(0, 0);
    checkOutput("orphan_cleared", 64'(err_orphan), 64'd0);

    for (int k = 0; k < 1200; k++) step(2, k);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
